decode_stage: RTL and testbench

- MIPS instruction decode stage, directly downstream of fetch_stage.
- Consumes the fetched instruction and its PC+4.
- Holds the 32x32 general-purpose register file with one write-back port.
- Decodes opcode into control signals, extends the immediate, and registers all results into the ID/EX pipeline register feeding the execute stage.

---
 rtl/decode_stage.sv | 250 +++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: MIPS instruction decode stage.
// Holds the 32-entry register file with one write-back port and a same-cycle
// write-to-read bypass. It decodes the opcode into control signals, extends
// the immediate, and registers everything into the ID/EX pipeline register.
module decode_stage #(
  parameter int NB_DATA     = 32,
  parameter int NB_REG_ADDR = 5,
  parameter int NB_PC       = 32
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic [NB_DATA-1:0]     i_instruction,
  input  logic [NB_PC-1:0]       i_pc_next,
  input  logic                   i_valid,
  input  logic                   i_stall,
  input  logic                   i_flush,
  input  logic                   i_wb_write,
  input  logic [NB_REG_ADDR-1:0] i_wb_addr,
  input  logic [NB_DATA-1:0]     i_wb_data,
  output logic                   o_valid,
  output logic [NB_PC-1:0]       o_pc_next,
  output logic [NB_DATA-1:0]     o_rs_data,
  output logic [NB_DATA-1:0]     o_rt_data,
  output logic [NB_DATA-1:0]     o_imm_ext,
  output logic [NB_PC-1:0]       o_jump_target,
  output logic [NB_REG_ADDR-1:0] o_rs,
  output logic [NB_REG_ADDR-1:0] o_rt,
  output logic [NB_REG_ADDR-1:0] o_rd,
  output logic [4:0]             o_shamt,
  output logic [5:0]             o_funct,
  output logic                   o_reg_write,
  output logic                   o_mem_read,
  output logic                   o_mem_write,
  output logic                   o_mem_to_reg,
  output logic                   o_alu_src,
  output logic                   o_reg_dst,
  output logic                   o_branch,
  output logic                   o_jump,
  output logic [2:0]             o_alu_op
);

  localparam int NREGS = 2 ** NB_REG_ADDR;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_FUNC = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b100;

  // One ID/EX pipeline entry.
  typedef struct packed {
    logic                   valid;
    logic [NB_PC-1:0]       pc_next;
    logic [NB_DATA-1:0]     rs_data;
    logic [NB_DATA-1:0]     rt_data;
    logic [NB_DATA-1:0]     imm_ext;
    logic [NB_PC-1:0]       jump_target;
    logic [NB_REG_ADDR-1:0] rs;
    logic [NB_REG_ADDR-1:0] rt;
    logic [NB_REG_ADDR-1:0] rd;
    logic [4:0]             shamt;
    logic [5:0]             funct;
    logic                   reg_write;
    logic                   mem_read;
    logic                   mem_write;
    logic                   mem_to_reg;
    logic                   alu_src;
    logic                   reg_dst;
    logic                   branch;
    logic                   jump;
    logic [2:0]             alu_op;
  } idex_t;

  // Instruction fields.
  logic [5:0]             opcode;
  logic [NB_REG_ADDR-1:0] rs_addr;
  logic [NB_REG_ADDR-1:0] rt_addr;

  assign opcode  = i_instruction[31:26];
  assign rs_addr = i_instruction[25:21];
  assign rt_addr = i_instruction[20:16];

  // The register file is a flop array: it must clear asynchronously on reset.
  // Entry 0 is never written and is also forced to zero on read.
  logic [NB_DATA-1:0] rf_q [0:NREGS-1];
  logic               wb_en;

  assign wb_en = i_wb_write && (i_wb_addr != '0);

  // Register file write port. A stall does not block write-back.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < NREGS; i++) begin
        rf_q[i] <= '0;
      end
    end else if (wb_en) begin
      rf_q[i_wb_addr] <= i_wb_data;
    end
  end

  // Read ports: r0 reads as zero, and a same-cycle write-back is bypassed.
  logic [NB_DATA-1:0] rs_rdata;
  logic [NB_DATA-1:0] rt_rdata;

  // rs read port with bypass.
  always_comb begin
    rs_rdata = rf_q[rs_addr];
    if (rs_addr == '0) begin
      rs_rdata = '0;
    end else if (wb_en && (i_wb_addr == rs_addr)) begin
      rs_rdata = i_wb_data;
    end
  end

  // rt read port with bypass.
  always_comb begin
    rt_rdata = rf_q[rt_addr];
    if (rt_addr == '0) begin
      rt_rdata = '0;
    end else if (wb_en && (i_wb_addr == rt_addr)) begin
      rt_rdata = i_wb_data;
    end
  end

  // Decode the current instruction into a full ID/EX entry.
  idex_t dec;
  logic  zero_ext;

  always_comb begin
    dec             = '0;
    dec.valid       = 1'b1;
    dec.pc_next     = i_pc_next;
    dec.rs_data     = rs_rdata;
    dec.rt_data     = rt_rdata;
    dec.jump_target = {i_pc_next[NB_PC-1:28], i_instruction[25:0], 2'b00};
    dec.rs          = rs_addr;
    dec.rt          = rt_addr;
    dec.rd          = i_instruction[15:11];
    dec.shamt       = i_instruction[10:6];
    dec.funct       = i_instruction[5:0];
    zero_ext        = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        dec.reg_write = 1'b1;
        dec.reg_dst   = 1'b1;
        dec.alu_op    = ALU_FUNC;
      end
      OP_LW: begin
        dec.reg_write  = 1'b1;
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.alu_src    = 1'b1;
        dec.alu_op     = ALU_ADD;
      end
      OP_SW: begin
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_op    = ALU_ADD;
      end
      OP_BEQ: begin
        dec.branch = 1'b1;
        dec.alu_op = ALU_SUB;
      end
      OP_ADDI: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_op    = ALU_ADD;
      end
      OP_ANDI: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_op    = ALU_AND;
        zero_ext      = 1'b1;
      end
      OP_ORI: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_op    = ALU_OR;
        zero_ext      = 1'b1;
      end
      OP_J: begin
        dec.jump   = 1'b1;
        dec.alu_op = ALU_ADD;
      end
      default: begin
        // Unknown opcodes flow down the pipe as a valid nop.
      end
    endcase
    if (zero_ext) begin
      dec.imm_ext = {{(NB_DATA-16){1'b0}}, i_instruction[15:0]};
    end else begin
      dec.imm_ext = {{(NB_DATA-16){i_instruction[15]}}, i_instruction[15:0]};
    end
  end

  // Next ID/EX entry: a flush beats a stall; an invalid fetch loads a bubble.
  idex_t idex_q;
  idex_t idex_d;

  always_comb begin
    idex_d = dec;
    if (i_flush) begin
      idex_d = '0;
    end else if (i_stall) begin
      idex_d = idex_q;
    end else if (!i_valid) begin
      idex_d = '0;
    end
  end

  // ID/EX pipeline register.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      idex_q <= '0;
    end else begin
      idex_q <= idex_d;
    end
  end

  assign o_valid       = idex_q.valid;
  assign o_pc_next     = idex_q.pc_next;
  assign o_rs_data     = idex_q.rs_data;
  assign o_rt_data     = idex_q.rt_data;
  assign o_imm_ext     = idex_q.imm_ext;
  assign o_jump_target = idex_q.jump_target;
  assign o_rs          = idex_q.rs;
  assign o_rt          = idex_q.rt;
  assign o_rd          = idex_q.rd;
  assign o_shamt       = idex_q.shamt;
  assign o_funct       = idex_q.funct;
  assign o_reg_write   = idex_q.reg_write;
  assign o_mem_read    = idex_q.mem_read;
  assign o_mem_write   = idex_q.mem_write;
  assign o_mem_to_reg  = idex_q.mem_to_reg;
  assign o_alu_src     = idex_q.alu_src;
  assign o_reg_dst     = idex_q.reg_dst;
  assign o_branch      = idex_q.branch;
  assign o_jump        = idex_q.jump;
  assign o_alu_op      = idex_q.alu_op;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: scoreboard bench for decode_stage. Each transaction
// pushes the expected ID/EX entry when it is driven and pops it for
// comparison after the capturing clock edge.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic [31:0] pc_next;
  logic        valid;
  logic        stall;
  logic        flush;
  logic        wb_write;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  logic        o_valid;
  logic [31:0] o_pc_next, o_rs_data, o_rt_data, o_imm_ext, o_jump_target;
  logic [4:0]  o_rs, o_rt, o_rd, o_shamt;
  logic [5:0]  o_funct;
  logic        o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg;
  logic        o_alu_src, o_reg_dst, o_branch, o_jump;
  logic [2:0]  o_alu_op;

  always #5 clk = ~clk;

  decode_stage dut (
    .i_clock(clk), .i_reset(rst_n), .i_instruction(instr), .i_pc_next(pc_next),
    .i_valid(valid), .i_stall(stall), .i_flush(flush),
    .i_wb_write(wb_write), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
    .o_valid(o_valid), .o_pc_next(o_pc_next), .o_rs_data(o_rs_data),
    .o_rt_data(o_rt_data), .o_imm_ext(o_imm_ext), .o_jump_target(o_jump_target),
    .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd), .o_shamt(o_shamt), .o_funct(o_funct),
    .o_reg_write(o_reg_write), .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
    .o_mem_to_reg(o_mem_to_reg), .o_alu_src(o_alu_src), .o_reg_dst(o_reg_dst),
    .o_branch(o_branch), .o_jump(o_jump), .o_alu_op(o_alu_op)
  );

  // ctrl = {reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst, branch, jump}
  typedef struct packed {
    logic        valid;
    logic [31:0] pc, rs_data, rt_data, imm, jt;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [7:0]  ctrl;
    logic [2:0]  alu_op;
  } entry_t;

  entry_t      exp_q[$];
  entry_t      last_exp;
  logic [31:0] model_rf [32];
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_txn = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rf_read(input logic [4:0] a, input logic wbw,
                                          input logic [4:0] wba, input logic [31:0] wbd);
    if (a == 5'd0) return 32'h0;
    if (wbw && (wba == a)) return wbd;
    return model_rf[a];
  endfunction

  function automatic entry_t predict(input logic [31:0] ins, input logic [31:0] pc,
                                     input logic wbw, input logic [4:0] wba,
                                     input logic [31:0] wbd);
    entry_t     e;
    logic [5:0] op;
    op        = ins[31:26];
    e         = '0;
    e.valid   = 1'b1;
    e.pc      = pc;
    e.rs      = ins[25:21];
    e.rt      = ins[20:16];
    e.rd      = ins[15:11];
    e.shamt   = ins[10:6];
    e.funct   = ins[5:0];
    e.rs_data = rf_read(ins[25:21], wbw, wba, wbd);
    e.rt_data = rf_read(ins[20:16], wbw, wba, wbd);
    e.jt      = {pc[31:28], ins[25:0], 2'b00};
    case (op)
      6'h00: begin e.ctrl = 8'b1000_0100; e.alu_op = 3'b010; end
      6'h23: begin e.ctrl = 8'b1101_1000; e.alu_op = 3'b000; end
      6'h2B: begin e.ctrl = 8'b0010_1000; e.alu_op = 3'b000; end
      6'h04: begin e.ctrl = 8'b0000_0010; e.alu_op = 3'b001; end
      6'h08: begin e.ctrl = 8'b1000_1000; e.alu_op = 3'b000; end
      6'h0C: begin e.ctrl = 8'b1000_1000; e.alu_op = 3'b011; end
      6'h0D: begin e.ctrl = 8'b1000_1000; e.alu_op = 3'b100; end
      6'h02: begin e.ctrl = 8'b0000_0001; e.alu_op = 3'b000; end
      default: begin e.ctrl = 8'h00; e.alu_op = 3'b000; end
    endcase
    if (op == 6'h0C || op == 6'h0D) e.imm = {16'h0000, ins[15:0]};
    else                            e.imm = {{16{ins[15]}}, ins[15:0]};
    return e;
  endfunction

  task automatic compare_outputs(input entry_t e);
    logic [7:0] ctrl;
    ctrl = {o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg,
            o_alu_src, o_reg_dst, o_branch, o_jump};
    check("valid",   32'(o_valid),  32'(e.valid));
    check("pc_next", o_pc_next,     e.pc);
    check("rs_data", o_rs_data,     e.rs_data);
    check("rt_data", o_rt_data,     e.rt_data);
    check("imm_ext", o_imm_ext,     e.imm);
    check("jump_tg", o_jump_target, e.jt);
    check("rs",      32'(o_rs),     32'(e.rs));
    check("rt",      32'(o_rt),     32'(e.rt));
    check("rd",      32'(o_rd),     32'(e.rd));
    check("shamt",   32'(o_shamt),  32'(e.shamt));
    check("funct",   32'(o_funct),  32'(e.funct));
    check("ctrl",    32'(ctrl),     32'(e.ctrl));
    check("alu_op",  32'(o_alu_op), 32'(e.alu_op));
  endtask

  // One transaction: drive at negedge, push expectation, pop after the edge.
  task automatic step(input logic [31:0] ins, input logic [31:0] pc, input logic v,
                      input logic st, input logic fl, input logic wbw,
                      input logic [4:0] wba, input logic [31:0] wbd);
    entry_t e;
    @(negedge clk);
    instr = ins; pc_next = pc; valid = v; stall = st; flush = fl;
    wb_write = wbw; wb_addr = wba; wb_data = wbd;
    if (fl)      e = '0;
    else if (st) e = last_exp;
    else if (!v) e = '0;
    else         e = predict(ins, pc, wbw, wba, wbd);
    exp_q.push_back(e);
    last_exp = e;
    @(posedge clk);
    if (wbw && wba != 5'd0) model_rf[wba] = wbd;
    #1;
    if (exp_q.size() == 0) begin
      check("queue_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      compare_outputs(e);
    end
    n_txn++;
    $display("txn %0d: instr=%h v=%0b st=%0b fl=%0b wb=%0b r%0d=%h -> valid=%0b rs=%h rt=%h imm=%h",
             n_txn, ins, v, st, fl, wbw, wba, wbd, o_valid, o_rs_data, o_rt_data, o_imm_ext);
  endtask

  task automatic go_idle();
    instr = 32'h0; pc_next = 32'h0; valid = 1'b0; stall = 1'b0; flush = 1'b0;
    wb_write = 1'b0; wb_addr = 5'd0; wb_data = 32'h0;
  endtask

  initial begin
    logic [5:0]  ops [9];
    logic [31:0] r;
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h0C, 6'h0D, 6'h02, 6'h3F};
    for (int i = 0; i < 32; i++) model_rf[i] = 32'h0;
    last_exp = '0;
    rst_n = 1'b0;
    go_idle();
    valid = 1'b1; instr = 32'h00600820; pc_next = 32'h1234_5678;
    repeat (2) @(negedge clk);
    compare_outputs('0);
    go_idle();
    rst_n = 1'b1;

    // Write r3 then read it through an R-type add r1,r3,r0.
    step(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 32'hDEADBEEF);
    step(32'h00600820, 32'h0000_0104, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    check("wr_rs_data", o_rs_data, 32'hDEADBEEF);
    check("wr_rd", 32'(o_rd), 32'd1);
    check("wr_alu_op", 32'(o_alu_op), 32'd2);

    // Same-cycle bypass into lw r2,-4(r4).
    step(32'h8C82FFFC, 32'h0000_0108, 1'b1, 1'b0, 1'b0, 1'b1, 5'd4, 32'h12345678);
    check("byp_rs_data", o_rs_data, 32'h12345678);
    check("byp_imm", o_imm_ext, 32'hFFFFFFFC);
    check("byp_mem_read", 32'(o_mem_read), 32'd1);

    // r0 is write-protected; ori zero-extends.
    step(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'hFFFFFFFF);
    step(32'h34018000, 32'h0000_010C, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    check("r0_rs_data", o_rs_data, 32'h0);
    check("r0_imm", o_imm_ext, 32'h00008000);
    check("r0_alu_op", 32'(o_alu_op), 32'd4);

    // beq, hold it through two stalls, then flush while stalled.
    step(32'h10220003, 32'h0000_0110, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    step(32'h8C82FFFC, 32'h0000_0114, 1'b1, 1'b1, 1'b0, 1'b1, 5'd7, 32'h0000_0077);
    step(32'h00600820, 32'h0000_0118, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    check("stall_branch", 32'(o_branch), 32'd1);
    step(32'h00600820, 32'h0000_011C, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0);
    check("flush_valid", 32'(o_valid), 32'd0);
    // The write made during the stall must have landed: add r1,r7,r0.
    step(32'h00E00820, 32'h0000_0120, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    check("stall_wb", o_rs_data, 32'h0000_0077);

    // Jump target.
    step(32'h08100040, 32'hA0000010, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    check("jump_target", o_jump_target, 32'hA0400100);
    check("jump_regwr", 32'(o_reg_write), 32'd0);

    // Random mix of opcodes, write-backs, stalls, flushes and bubbles.
    for (int i = 0; i < 60; i++) begin
      r = $urandom();
      step({ops[$urandom_range(0, 8)], r[25:0]}, $urandom(),
           ($urandom_range(0, 7) != 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 1) == 1),
           5'($urandom_range(0, 31)), $urandom());
    end

    // Mid-run reset with a valid instruction present: add r1,r5,r0.
    step(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h55AA55AA);
    step(32'h00A00820, 32'h0000_0200, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    check("pre_rst_r5", o_rs_data, 32'h55AA55AA);
    #2;
    rst_n = 1'b0;
    #1;
    compare_outputs('0);
    @(negedge clk);
    go_idle();
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) model_rf[i] = 32'h0;
    last_exp = '0;
    step(32'h00A00820, 32'h0000_0204, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    check("post_rst_r5", o_rs_data, 32'h0);
    check("post_rst_valid", 32'(o_valid), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
